// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - 8N1 UART transmitter that pops bytes from an upstream registered-output FIFO
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_i,
  input  logic          fifo_empty_i,
  output logic          fifo_rd_en_o,
  input  logic [DW-1:0] fifo_rd_data_i,
  output logic          tx_o,
  output logic          busy_o,
  output logic          byte_done_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (enable_i && !fifo_empty_i) state_d = POP;
      end
      POP: begin
        state_d = LATCH;
      end
      LATCH: begin
        shift_d = fifo_rd_data_i[7:0];
        bit_d   = 3'd0;
        state_d = START;
      end
      START: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        if (bit_end) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // tx is registered, so its next value follows the next state to line up with it
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Decoded outputs are masked by rst so nothing leaks out while reset is held
  assign tx_o         = tx_q;
  assign busy_o       = (state_q != IDLE) && !rst;
  assign fifo_rd_en_o = (state_q == POP) && !rst;
  assign byte_done_o  = (state_q == STOP) && bit_end && !rst;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4
module tb_fifo_uart_tx;

  localparam int C = 4;
  localparam int FRAME = 10 * C;

  logic       clk;
  logic       rst;
  logic       enable_i;
  logic       fifo_empty_i;
  logic       fifo_rd_en_o;
  logic [7:0] fifo_rd_data_i;
  logic       tx_o;
  logic       busy_o;
  logic       byte_done_o;

  int checks;
  int errors;
  int pop_cnt;
  int done_cnt;

  logic [7:0] mem [16];
  int         wr_ptr;
  int         rd_ptr;

  logic tx_s   [FRAME];
  logic done_s [FRAME];
  logic busy_after;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DW(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .fifo_rd_data_i (fifo_rd_data_i),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .byte_done_o    (byte_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output FIFO model: data appears the cycle after the pop
  assign fifo_empty_i = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en_o && (wr_ptr != rd_ptr)) begin
      fifo_rd_data_i <= mem[rd_ptr % 16];
      rd_ptr         <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd_en_o) pop_cnt = pop_cnt + 1;
    if (byte_done_o)  done_cnt = done_cnt + 1;
  end

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    int b;
    b = k / C;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 16] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Advance negedge by negedge until tx goes low; returns the number of high cycles seen
  task automatic wait_start(output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (tx_o === 1'b0) break;
      n = n + 1;
      if (n > 200) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL wait_start: tx_o never went low (timeout after %0d cycles), required a start bit", n);
        break;
      end
    end
  endtask

  task automatic capture(input int drop_at);
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      tx_s[k]   = tx_o;
      done_s[k] = byte_done_o;
      if (k == drop_at) enable_i = 1'b0;
    end
    @(negedge clk);
    busy_after = busy_o;
  endtask

  task automatic check_frame(input string name, input logic [7:0] d);
    for (int k = 0; k < FRAME; k++) begin
      checks = checks + 1;
      if (tx_s[k] !== exp_bit(d, k)) begin
        errors = errors + 1;
        $display("FAIL %s tx cycle %0d: got %b, expected %b", name, k, tx_s[k], exp_bit(d, k));
      end
      checks = checks + 1;
      if (done_s[k] !== (k == FRAME - 1)) begin
        errors = errors + 1;
        $display("FAIL %s byte_done cycle %0d: got %b, expected %b", name, k, done_s[k], (k == FRAME - 1));
      end
    end
    checks = checks + 1;
    if (busy_after !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL %s busy after frame: got %b, expected 0", name, busy_after);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks = checks + 4;
      if (tx_o !== 1'b1)         begin errors++; $display("FAIL reset tx_o: got %b, expected 1", tx_o); end
      if (fifo_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset rd_en: got %b, expected 0", fifo_rd_en_o); end
      if (busy_o !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b, expected 0", busy_o); end
      if (byte_done_o !== 1'b0)  begin errors++; $display("FAIL reset byte_done: got %b, expected 0", byte_done_o); end
    end
    rst = 1'b0;
  endtask

  task automatic test_empty_fifo();
    enable_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks = checks + 3;
      if (fifo_rd_en_o !== 1'b0) begin errors++; $display("FAIL empty rd_en cycle %0d: got %b, expected 0", i, fifo_rd_en_o); end
      if (tx_o !== 1'b1)         begin errors++; $display("FAIL empty tx_o cycle %0d: got %b, expected 1", i, tx_o); end
      if (busy_o !== 1'b0)       begin errors++; $display("FAIL empty busy cycle %0d: got %b, expected 0", i, busy_o); end
    end
  endtask

  task automatic test_single_byte();
    int n;
    int p0, d0;
    p0 = pop_cnt;
    d0 = done_cnt;
    push(8'hA5);
    wait_start(n);
    capture(-1);
    check_frame("single_a5", 8'hA5);
    checks = checks + 2;
    if (pop_cnt - p0 !== 1)  begin errors++; $display("FAIL single pops: got %0d, expected 1", pop_cnt - p0); end
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single done pulses: got %0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int n;
    int p0;
    p0 = pop_cnt;
    push(8'h00);
    push(8'hFF);
    wait_start(n);
    capture(-1);
    check_frame("b2b_00", 8'h00);
    wait_start(n);
    checks = checks + 1;
    if (n !== 2) begin
      // busy_after consumed one idle-high cycle already, so 2 more make 3
      errors++; $display("FAIL b2b gap: got %0d idle cycles, expected 3", n + 1);
    end
    capture(-1);
    check_frame("b2b_ff", 8'hFF);
    checks = checks + 1;
    if (pop_cnt - p0 !== 2) begin errors++; $display("FAIL b2b pops: got %0d, expected 2", pop_cnt - p0); end
  endtask

  task automatic test_enable_drop();
    int n;
    int p0;
    p0 = pop_cnt;
    enable_i = 1'b1;
    push(8'h3C);
    push(8'h81);
    wait_start(n);
    capture(4 * C + 1);
    check_frame("drop_3c", 8'h3C);
    repeat (30) @(negedge clk);
    checks = checks + 3;
    if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL drop pops: got %0d, expected 1", pop_cnt - p0); end
    if (busy_o !== 1'b0)    begin errors++; $display("FAIL drop busy: got %b, expected 0", busy_o); end
    if (fifo_empty_i !== 1'b0) begin errors++; $display("FAIL drop fifo level: empty=%b, expected 0", fifo_empty_i); end
  endtask

  task automatic test_disabled_idle();
    int p0;
    p0 = pop_cnt;
    enable_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks = checks + 2;
      if (fifo_rd_en_o !== 1'b0) begin errors++; $display("FAIL disabled rd_en cycle %0d: got %b, expected 0", i, fifo_rd_en_o); end
      if (tx_o !== 1'b1)         begin errors++; $display("FAIL disabled tx_o cycle %0d: got %b, expected 1", i, tx_o); end
    end
    checks = checks + 1;
    if (pop_cnt !== p0) begin errors++; $display("FAIL disabled pops: got %0d, expected 0", pop_cnt - p0); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int p0, d0;
    push(8'h5A);
    enable_i = 1'b1;
    wait_start(n);
    repeat (2 * C + 2) @(negedge clk);
    p0 = pop_cnt;
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks = checks + 4;
    if (tx_o !== 1'b1)         begin errors++; $display("FAIL midrst tx_o: got %b, expected 1", tx_o); end
    if (busy_o !== 1'b0)       begin errors++; $display("FAIL midrst busy: got %b, expected 0", busy_o); end
    if (byte_done_o !== 1'b0)  begin errors++; $display("FAIL midrst byte_done: got %b, expected 0", byte_done_o); end
    if (fifo_rd_en_o !== 1'b0) begin errors++; $display("FAIL midrst early pop: got %b, expected 0", fifo_rd_en_o); end
    wait_start(n);
    capture(-1);
    check_frame("midrst_5a", 8'h5A);
    checks = checks + 2;
    if (pop_cnt - p0 !== 1)  begin errors++; $display("FAIL midrst pops: got %0d, expected 1", pop_cnt - p0); end
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midrst done pulses: got %0d, expected 1", done_cnt - d0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pop_cnt = 0;
    done_cnt = 0;
    wr_ptr = 0;
    rd_ptr = 0;
    fifo_rd_data_i = 8'h00;
    rst = 1'b1;
    enable_i = 1'b0;
    test_reset();
    test_empty_fifo();
    test_single_byte();
    test_back_to_back();
    test_enable_drop();
    test_disabled_idle();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
